// File: rtl/ddr3_reset_sequencer.sv
// ddr3_reset_sequencer
//   Power-up and re-initialisation reset sequencer for the DDR3 controller.
//   It turns PLL lock and the asynchronous chip reset into a synchronously
//   released fabric reset, JEDEC-timed DDR3 RESET#/CKE sequencing and an
//   init_done flag that gates the command sequencer.
//
//   Optional build macro: DDR3_RSTSEQ_LOCK_SYNC_EN
//     defined   - locked passes through a two-flop synchroniser before use
//                 (2 cycles of added latency on lock-related transitions)
//     undefined - locked is assumed synchronous to clk and used directly
//
// Ports
//   clk        in   controller clock
//   rst        in   asynchronous active-high reset
//   locked     in   PLL lock
//   start      in   single-cycle re-init request (honoured only in DONE)
//   fab_rst    out  synchronous fabric reset, active-high
//   ddr_rst_n  out  DDR3 RESET#
//   ddr_cke    out  DDR3 CKE
//   init_done  out  sequence complete
//   state      out  current state encoding, for debug
module ddr3_reset_sequencer #(
  parameter int unsigned CNT_WIDTH    = 17,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned RESET_CYCLES = 40000,
  parameter int unsigned CKE_CYCLES   = 100000,
  parameter int unsigned TXPR_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       start,
  output logic       fab_rst,
  output logic       ddr_rst_n,
  output logic       ddr_cke,
  output logic       init_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    LOCK_STAB  = 3'd1,
    RESET_HOLD = 3'd2,
    CKE_WAIT   = 3'd3,
    TXPR       = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LOCK_LOAD  = CNT_WIDTH'(LOCK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RESET_LOAD = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CKE_LOAD   = CNT_WIDTH'(CKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TXPR_LOAD  = CNT_WIDTH'(TXPR_CYCLES - 1);

  state_t               cur_state;
  state_t               nxt_state;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] nxt_count;
  logic                 lk;

`ifdef DDR3_RSTSEQ_LOCK_SYNC_EN
  logic [1:0] lock_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_sync <= '0;
    else     lock_sync <= {lock_sync[0], locked};
  end

  assign lk = lock_sync[1];
`else
  assign lk = locked;
`endif

  // Next-state/next-count decode. Lock loss takes priority over both start
  // and counter expiry; the counter only decrements while non-zero, so it
  // cannot wrap.
  always_comb begin
    nxt_state = cur_state;
    nxt_count = count;
    case (cur_state)
      WAIT_LOCK: begin
        if (lk) begin
          nxt_state = LOCK_STAB;
          nxt_count = LOCK_LOAD;
        end
      end
      LOCK_STAB, RESET_HOLD, CKE_WAIT, TXPR: begin
        if (!lk) begin
          nxt_state = WAIT_LOCK;
          nxt_count = '0;
        end else if (count == '0) begin
          case (cur_state)
            LOCK_STAB: begin
              nxt_state = RESET_HOLD;
              nxt_count = RESET_LOAD;
            end
            RESET_HOLD: begin
              nxt_state = CKE_WAIT;
              nxt_count = CKE_LOAD;
            end
            CKE_WAIT: begin
              nxt_state = TXPR;
              nxt_count = TXPR_LOAD;
            end
            default: begin
              nxt_state = DONE;
              nxt_count = '0;
            end
          endcase
        end else begin
          nxt_count = count - 1'b1;
        end
      end
      DONE: begin
        if (!lk) begin
          nxt_state = WAIT_LOCK;
          nxt_count = '0;
        end else if (start) begin
          nxt_state = RESET_HOLD;
          nxt_count = RESET_LOAD;
        end
      end
      default: begin
        nxt_state = WAIT_LOCK;
        nxt_count = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= WAIT_LOCK;
      count     <= '0;
      fab_rst   <= 1'b1;
      ddr_rst_n <= 1'b0;
      ddr_cke   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      count     <= nxt_count;
      fab_rst   <= (nxt_state == WAIT_LOCK) || (nxt_state == LOCK_STAB);
      ddr_rst_n <= (nxt_state == CKE_WAIT) || (nxt_state == TXPR) ||
                   (nxt_state == DONE);
      ddr_cke   <= (nxt_state == TXPR) || (nxt_state == DONE);
      init_done <= (nxt_state == DONE);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_ddr3_reset_sequencer.sv
// tb_ddr3_reset_sequencer
//   Directed bench for ddr3_reset_sequencer with LOCK=4, RESET=8, CKE=10,
//   TXPR=5. Edge numbering: edge 0 is the first rising clk edge with rst low.
//   LAT is the extra lock latency when the synchroniser macro is defined.
module tb_ddr3_reset_sequencer;

  localparam int unsigned CW    = 17;
  localparam int unsigned LOCKC = 4;
  localparam int unsigned RSTC  = 8;
  localparam int unsigned CKEC  = 10;
  localparam int unsigned TXPRC = 5;
`ifdef DDR3_RSTSEQ_LOCK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       locked;
  logic       start;
  logic       fab_rst;
  logic       ddr_rst_n;
  logic       ddr_cke;
  logic       init_done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int edge_n = -1;

  ddr3_reset_sequencer #(
    .CNT_WIDTH   (CW),
    .LOCK_CYCLES (LOCKC),
    .RESET_CYCLES(RSTC),
    .CKE_CYCLES  (CKEC),
    .TXPR_CYCLES (TXPRC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .start    (start),
    .fab_rst  (fab_rst),
    .ddr_rst_n(ddr_rst_n),
    .ddr_cke  (ddr_cke),
    .init_done(init_done),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic fr,
                            input logic rn, input logic ck, input logic dn);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".fab_rst"}, 32'(fab_rst), 32'(fr));
    check({tag, ".ddr_rst_n"}, 32'(ddr_rst_n), 32'(rn));
    check({tag, ".ddr_cke"}, 32'(ddr_cke), 32'(ck));
    check({tag, ".init_done"}, 32'(init_done), 32'(dn));
  endtask

  // Apply reset, check the reset values asynchronously, release on a falling
  // edge so the next rising edge is edge 0.
  task automatic do_reset(input logic lk_init);
    rst    = 1'b1;
    start  = 1'b0;
    locked = lk_init;
    #3;
    check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = -1;
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_cke)   check("cke_needs_rstn", 32'(ddr_rst_n), 32'd1);
      if (init_done) check("done_needs_cke", 32'(ddr_cke), 32'd1);
      check("cnt_no_underflow", 32'(dut.count > CW'(CKEC - 1)), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; locked = 1'b1; start = 1'b0;

    // Basic sequence
    do_reset(1'b1);
    step_to(LAT);      check("b.lock_stab",  32'(state), 32'd1);
    step_to(3 + LAT);  check("b.stab_last",  32'(state), 32'd1);
    step_to(4 + LAT);  check_outs("b.reset_hold", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step_to(11 + LAT); check("b.rh_last",    32'(state), 32'd2);
    step_to(12 + LAT); check_outs("b.cke_wait", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step_to(21 + LAT); check("b.cw_last",    32'(state), 32'd3);
    step_to(22 + LAT); check_outs("b.txpr", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step_to(26 + LAT); check("b.txpr_last",  32'(state), 32'd4);
    step_to(27 + LAT); check_outs("b.done", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);

    // Re-init: start sampled 3 edges after DONE
    step_to(29 + LAT); start = 1'b1;
    step_to(30 + LAT); start = 1'b0;
    check_outs("ri.reset_hold", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step_to(52 + LAT); check("ri.txpr", 32'(state), 32'd4);
    step_to(53 + LAT); check_outs("ri.done", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);

    // Lock glitch during CKE_WAIT
    do_reset(1'b1);
    step_to(14); locked = 1'b0;
    step_to(15); locked = 1'b1;
    step_to(15 + LAT); check_outs("lg.wait_lock", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step_to(16 + LAT); check("lg.relock", 32'(state), 32'd1);
    step_to(42 + LAT); check("lg.txpr", 32'(state), 32'd4);
    step_to(43 + LAT); check_outs("lg.done", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);

    // start in CKE_WAIT is ignored
    do_reset(1'b1);
    step_to(14 + LAT); start = 1'b1;
    step_to(15 + LAT); start = 1'b0;
    check("si.still_cw", 32'(state), 32'd3);
    step_to(26 + LAT); check("si.txpr", 32'(state), 32'd4);
    step_to(27 + LAT); check("si.done", 32'(state), 32'd5);

    // start and lock loss seen on the same edge in DONE: lock loss wins
    step_to(29); locked = 1'b0;
    step_to(29 + LAT); start = 1'b1;
    step_to(30 + LAT); start = 1'b0;
    check_outs("sl.wait_lock", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset mid-TXPR, then a full re-run
    do_reset(1'b1);
    step_to(24 + LAT);
    check("ar.in_txpr", 32'(state), 32'd4);
    #2 rst = 1'b1;
    #1 check_outs("ar.async", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    edge_n = -1;
    step_to(26 + LAT); check("ar.txpr", 32'(state), 32'd4);
    step_to(27 + LAT); check_outs("ar.done", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);

    // Toggling lock never gets past LOCK_STAB
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      locked = ~locked;
      step();
      check("tg.no_reset_hold", 32'(state == 3'd2), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
